// File: rtl/rf_multiport_sb_if.sv
// Bus bundle for the multi-port register file: write ports, read ports,
// destination allocation and scoreboard/status outputs.
interface rf_multiport_sb_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_READ   = 2,
  parameter int NUM_WRITE  = 2
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [NUM_WRITE-1:0]            wen;
  logic [NUM_WRITE*ADDR_WIDTH-1:0] waddr;
  logic [NUM_WRITE*DATA_WIDTH-1:0] wdata;
  logic [NUM_READ*ADDR_WIDTH-1:0]  raddr;
  logic [NUM_READ*DATA_WIDTH-1:0]  rdata;
  logic [NUM_READ-1:0]             rvalid;
  logic                            alloc_en;
  logic [ADDR_WIDTH-1:0]           alloc_addr;
  logic [DEPTH-1:0]                busy_vec;
  logic [31:0]                     wr_count;

  // Decode/writeback side drives requests and observes the file.
  modport master (
    output wen, waddr, wdata, raddr, alloc_en, alloc_addr,
    input  rdata, rvalid, busy_vec, wr_count
  );

  // Register file side.
  modport slave (
    input  wen, waddr, wdata, raddr, alloc_en, alloc_addr,
    output rdata, rvalid, busy_vec, wr_count
  );
endinterface

// File: rtl/rf_multiport_sb.sv
// Multi-port integer register file with per-register busy scoreboard,
// optional hardwired zero register and optional same-cycle write bypass.
module rf_multiport_sb #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_READ   = 2,
  parameter int NUM_WRITE  = 2,
  parameter bit ZERO_REG   = 1'b1,
  parameter bit BYPASS     = 1'b1
) (
  input logic               clk,
  input logic               rst,
  rf_multiport_sb_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs      [DEPTH];
  logic [DATA_WIDTH-1:0] regs_next [DEPTH];
  logic [DEPTH-1:0]      busy;
  logic [DEPTH-1:0]      busy_next;
  logic [DEPTH-1:0]      wr_hit;
  logic [DEPTH-1:0]      alloc_hit;
  logic [31:0]           count;
  logic [31:0]           count_next;
  logic [31:0]           n_commit;
  logic [32:0]           count_sum;

  logic [ADDR_WIDTH-1:0] wa [NUM_WRITE];
  logic [DATA_WIDTH-1:0] wd [NUM_WRITE];
  logic [NUM_WRITE-1:0]  commit;

  // Unpack write ports; a write to register 0 is dropped when it is hardwired.
  generate
    for (genvar gi = 0; gi < NUM_WRITE; gi++) begin : g_wport
      assign wa[gi]     = bus.waddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign wd[gi]     = bus.wdata[gi*DATA_WIDTH +: DATA_WIDTH];
      assign commit[gi] = bus.wen[gi] && !(ZERO_REG && (wa[gi] == '0));
    end
  endgenerate

  // Merge write ports in ascending order so the highest port index wins a collision.
  always_comb begin
    wr_hit = '0;
    for (int r = 0; r < DEPTH; r++) begin
      regs_next[r] = regs[r];
    end
    for (int i = 0; i < NUM_WRITE; i++) begin
      if (commit[i]) begin
        wr_hit[wa[i]]    = 1'b1;
        regs_next[wa[i]] = wd[i];
      end
    end
  end

  // New producer marking; register 0 is never tracked when hardwired.
  always_comb begin
    alloc_hit = '0;
    if (bus.alloc_en && !(ZERO_REG && (bus.alloc_addr == '0))) begin
      alloc_hit[bus.alloc_addr] = 1'b1;
    end
  end

  // Writes retire their producer, but a same-cycle allocation re-arms busy.
  assign busy_next = (busy & ~wr_hit) | alloc_hit;

  // Count distinct registers written this cycle, saturating at all-ones.
  always_comb begin
    n_commit   = 32'($countones(wr_hit));
    count_sum  = {1'b0, count} + {1'b0, n_commit};
    count_next = count_sum[32] ? '1 : count_sum[31:0];
  end

  // Architectural state: register array, scoreboard and write counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs[r] <= '0;
      end
      busy  <= '0;
      count <= '0;
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        regs[r] <= regs_next[r];
      end
      busy  <= busy_next;
      count <= count_next;
    end
  end

  assign bus.busy_vec = busy;
  assign bus.wr_count = count;

  // Combinational read ports with optional forwarding of in-flight write data.
  generate
    for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_rport
      logic [ADDR_WIDTH-1:0] ra;
      logic [DATA_WIDTH-1:0] rd;
      logic                  rv;

      assign ra = bus.raddr[gi*ADDR_WIDTH +: ADDR_WIDTH];

      // Priority: reset, then zero register, then bypass (highest port), then storage.
      always_comb begin
        rd = regs[ra];
        rv = ~busy[ra];
        if (BYPASS) begin
          for (int i = 0; i < NUM_WRITE; i++) begin
            if (bus.wen[i] && (wa[i] == ra) && !(ZERO_REG && (ra == '0))) begin
              rd = wd[i];
              rv = 1'b1;
            end
          end
        end
        if (ZERO_REG && (ra == '0)) begin
          rd = '0;
          rv = 1'b1;
        end
        if (rst) begin
          rd = '0;
          rv = 1'b1;
        end
      end

      assign bus.rdata[gi*DATA_WIDTH +: DATA_WIDTH] = rd;
      assign bus.rvalid[gi]                         = rv;
    end
  endgenerate
endmodule

// File: tb/tb_rf_multiport_sb.sv
// Scoreboard bench: directed cases on a bypassing and a non-bypassing
// 2R/2W file, then random traffic on a 4R/3W 64-bit file against a model.
module tb_rf_multiport_sb;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rf_multiport_sb_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_READ(2), .NUM_WRITE(2)) bus_a ();
  rf_multiport_sb_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_READ(2), .NUM_WRITE(2)) bus_b ();
  rf_multiport_sb_if #(.ADDR_WIDTH(4), .DATA_WIDTH(64), .NUM_READ(4), .NUM_WRITE(3)) bus_w ();

  rf_multiport_sb #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_READ(2), .NUM_WRITE(2),
                    .ZERO_REG(1'b1), .BYPASS(1'b1))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  rf_multiport_sb #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_READ(2), .NUM_WRITE(2),
                    .ZERO_REG(1'b1), .BYPASS(1'b0))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));
  rf_multiport_sb #(.ADDR_WIDTH(4), .DATA_WIDTH(64), .NUM_READ(4), .NUM_WRITE(3),
                    .ZERO_REG(1'b1), .BYPASS(1'b1))
    dut_w (.clk(clk), .rst(rst), .bus(bus_w));

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  logic [63:0] m_regs [16];
  logic [15:0] m_busy;
  logic [31:0] m_cnt;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_v(input string tag, input logic [63:0] v);
    exp_q.push_back('{tag, v});
  endtask

  task automatic observe(input logic [63:0] obs);
    exp_t e;
    if (exp_q.size() == 0) begin
      check_val("sb_depth", 64'(exp_q.size()), 64'd1);
    end else begin
      e = exp_q.pop_front();
      check_val(e.tag, obs, e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    bus_a.wen = '0; bus_a.waddr = '0; bus_a.wdata = '0;
    bus_a.raddr = '0; bus_a.alloc_en = 1'b0; bus_a.alloc_addr = '0;
    bus_b.wen = '0; bus_b.waddr = '0; bus_b.wdata = '0;
    bus_b.raddr = '0; bus_b.alloc_en = 1'b0; bus_b.alloc_addr = '0;
  endtask

  task automatic idle_w();
    bus_w.wen = '0; bus_w.waddr = '0; bus_w.wdata = '0;
    bus_w.raddr = '0; bus_w.alloc_en = 1'b0; bus_w.alloc_addr = '0;
  endtask

  task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
    bus_a.wen[p] = 1'b1; bus_a.waddr[p*5 +: 5] = a; bus_a.wdata[p*32 +: 32] = d;
    bus_b.wen[p] = 1'b1; bus_b.waddr[p*5 +: 5] = a; bus_b.wdata[p*32 +: 32] = d;
  endtask

  task automatic rd(input int p, input logic [4:0] a);
    bus_a.raddr[p*5 +: 5] = a;
    bus_b.raddr[p*5 +: 5] = a;
  endtask

  task automatic alloc(input logic [4:0] a);
    bus_a.alloc_en = 1'b1; bus_a.alloc_addr = a;
    bus_b.alloc_en = 1'b1; bus_b.alloc_addr = a;
  endtask

  // One random cycle on the wide file: comb reads checked before the edge,
  // scoreboard and counter checked after it.
  task automatic rand_cycle();
    logic [2:0]  we;
    logic [3:0]  wa [3];
    logic [63:0] wd [3];
    logic [3:0]  ra;
    logic        al;
    logic [3:0]  aa;
    logic [63:0] e_d;
    logic        e_v;
    logic [15:0] written;

    we = 3'($urandom_range(0, 7));
    for (int i = 0; i < 3; i++) begin
      wa[i] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 5));
      wd[i] = {$urandom, $urandom};
      bus_w.waddr[i*4 +: 4]   = wa[i];
      bus_w.wdata[i*64 +: 64] = wd[i];
    end
    bus_w.wen = we;
    al = ($urandom_range(0, 1) == 1);
    aa = 4'($urandom_range(0, 7));
    bus_w.alloc_en   = al;
    bus_w.alloc_addr = aa;

    for (int p = 0; p < 4; p++) begin
      ra = 4'($urandom_range(0, 7));
      bus_w.raddr[p*4 +: 4] = ra;
      e_d = m_regs[ra];
      e_v = ~m_busy[ra];
      if (ra == 4'd0) begin
        e_d = '0;
        e_v = 1'b1;
      end else begin
        for (int i = 2; i >= 0; i--) begin
          if (we[i] && wa[i] == ra) begin
            e_d = wd[i];
            e_v = 1'b1;
            break;
          end
        end
      end
      expect_v($sformatf("w_rdata%0d", p), e_d);
      expect_v($sformatf("w_rvalid%0d", p), 64'(e_v));
    end
    settle();
    for (int p = 0; p < 4; p++) begin
      observe(bus_w.rdata[p*64 +: 64]);
      observe(64'(bus_w.rvalid[p]));
    end

    written = '0;
    for (int i = 0; i < 3; i++) begin
      if (we[i] && wa[i] != 4'd0) begin
        m_regs[wa[i]] = wd[i];
        written[wa[i]] = 1'b1;
      end
    end
    m_cnt  = m_cnt + 32'($countones(written));
    m_busy = m_busy & ~written;
    if (al && aa != 4'd0) m_busy[aa] = 1'b1;
    expect_v("w_busy_vec", 64'(m_busy));
    expect_v("w_wr_count", 64'(m_cnt));
    tick();
    observe(64'(bus_w.busy_vec));
    observe(64'(bus_w.wr_count));
  endtask

  initial begin
    rst = 1'b0;
    idle();
    idle_w();
    #1 rst = 1'b1;
    #2;
    // Reset state while held.
    expect_v("rst_rdata", 64'd0);
    expect_v("rst_rvalid", 64'd3);
    expect_v("rst_busy", 64'd0);
    expect_v("rst_count", 64'd0);
    observe(64'(bus_a.rdata));
    observe(64'(bus_a.rvalid));
    observe(64'(bus_a.busy_vec));
    observe(64'(bus_a.wr_count));
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Zero register: write and alloc to r0 are ignored.
    idle(); wr(0, 5'd0, 32'h12345678); alloc(5'd0); rd(0, 5'd0);
    expect_v("zero_rdata", 64'd0);
    expect_v("zero_rvalid", 64'd1);
    settle();
    observe(64'(bus_a.rdata[31:0]));
    observe(64'(bus_a.rvalid[0]));
    expect_v("zero_busy0", 64'd0);
    expect_v("zero_count", 64'd0);
    tick();
    observe(64'(bus_a.busy_vec[0]));
    observe(64'(bus_a.wr_count));

    // Same-address collision: port 1 wins, counted once.
    idle(); wr(0, 5'd3, 32'h1111); wr(1, 5'd3, 32'h2222);
    expect_v("coll_r3", 64'h2222);
    expect_v("coll_count", 64'd1);
    tick();
    idle(); rd(0, 5'd3);
    settle();
    observe(64'(bus_a.rdata[31:0]));
    observe(64'(bus_a.wr_count));

    // Bypass vs no-bypass on a busy register.
    idle(); wr(0, 5'd7, 32'hAAAA); alloc(5'd7);
    expect_v("byp_busy7_a", 64'd1);
    expect_v("byp_busy7_b", 64'd1);
    tick();
    observe(64'(bus_a.busy_vec[7]));
    observe(64'(bus_b.busy_vec[7]));
    idle(); wr(1, 5'd7, 32'hCAFE); rd(0, 5'd7);
    expect_v("byp_rdata_a", 64'hCAFE);
    expect_v("byp_rvalid_a", 64'd1);
    expect_v("nobyp_rdata_b", 64'hAAAA);
    expect_v("nobyp_rvalid_b", 64'd0);
    settle();
    observe(64'(bus_a.rdata[31:0]));
    observe(64'(bus_a.rvalid[0]));
    observe(64'(bus_b.rdata[31:0]));
    observe(64'(bus_b.rvalid[0]));
    expect_v("byp_busy7_clr_a", 64'd0);
    expect_v("byp_busy7_clr_b", 64'd0);
    expect_v("byp_count", 64'd3);
    tick();
    observe(64'(bus_a.busy_vec[7]));
    observe(64'(bus_b.busy_vec[7]));
    observe(64'(bus_a.wr_count));
    idle(); rd(0, 5'd7);
    expect_v("nobyp_late_rdata", 64'hCAFE);
    expect_v("nobyp_late_rvalid", 64'd1);
    settle();
    observe(64'(bus_b.rdata[31:0]));
    observe(64'(bus_b.rvalid[0]));

    // Alloc/write race on an already-busy register.
    idle(); alloc(5'd9);
    expect_v("race_busy9_pre", 64'd1);
    tick();
    observe(64'(bus_a.busy_vec[9]));
    idle(); alloc(5'd9); wr(0, 5'd9, 32'h55);
    expect_v("race_rdata", 64'h55);
    expect_v("race_rvalid", 64'd0);
    expect_v("race_busy9", 64'd1);
    expect_v("race_count", 64'd4);
    tick();
    idle(); rd(1, 5'd9);
    settle();
    observe(64'(bus_a.rdata[63:32]));
    observe(64'(bus_a.rvalid[1]));
    observe(64'(bus_a.busy_vec[9]));
    observe(64'(bus_a.wr_count));

    // Asynchronous reset between edges, mid-run.
    idle(); wr(0, 5'd5, 32'hDEADBEEF); alloc(5'd6);
    expect_v("pre_rst_r5", 64'hDEADBEEF);
    expect_v("pre_rst_busy6", 64'd1);
    expect_v("pre_rst_count", 64'd5);
    tick();
    idle(); rd(0, 5'd5); rd(1, 5'd6);
    settle();
    observe(64'(bus_a.rdata[31:0]));
    observe(64'(bus_a.busy_vec[6]));
    observe(64'(bus_a.wr_count));
    wr(0, 5'd5, 32'h77);
    rst = 1'b1;
    #1;
    expect_v("arst_rdata", 64'd0);
    expect_v("arst_rvalid", 64'd3);
    expect_v("arst_busy", 64'd0);
    expect_v("arst_count", 64'd0);
    observe(64'(bus_a.rdata));
    observe(64'(bus_a.rvalid));
    observe(64'(bus_a.busy_vec));
    observe(64'(bus_a.wr_count));
    #1 rst = 1'b0;
    idle(); rd(0, 5'd5); rd(1, 5'd9);
    expect_v("post_rst_r5", 64'd0);
    expect_v("post_rst_r9", 64'd0);
    expect_v("post_rst_rvalid", 64'd3);
    tick();
    settle();
    observe(64'(bus_a.rdata[31:0]));
    observe(64'(bus_a.rdata[63:32]));
    observe(64'(bus_a.rvalid));

    // Random traffic on the wide configuration against the model.
    @(negedge clk);
    rst = 1'b1;
    #2 rst = 1'b0;
    for (int r = 0; r < 16; r++) m_regs[r] = '0;
    m_busy = '0;
    m_cnt  = '0;
    tick();
    for (int c = 0; c < 400; c++) begin
      rand_cycle();
    end
    idle_w();

    check_val("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
